// File: rtl/pg_ctrl.sv
// pg_ctrl: power-gating controller that sits beside one NoC switch.
//
// Watches the switch's incoming write requests and buffer occupancy. After
// IDLE_CYCLES consecutive idle cycles it clamps the switch outputs (ISO),
// then removes power and holds the switch in reset (SLEEP). A new write
// request, or dropping sleep_en, powers the domain back up. The domain then
// settles for WAKE_CYCLES cycles (WAKE) before the upstream handshake is
// released again (ACTIVE).
//
// Ports:
//   clk       in   rising-edge clock
//   a_rst     in   asynchronous active-low reset
//   in_w      in   [PORTS_NUM] upstream write requests (held until accepted)
//   busy      in   switch holds at least one buffered flit
//   sleep_en  in   global gating enable
//   pwr_on    out  power-switch enable for the switch domain
//   iso       out  isolation clamp on the switch outputs (1 = clamped)
//   sw_rst    out  switch reset (1 = held in reset)
//   in_r_en   out  [PORTS_NUM] mask ANDed with the switch in_r, all bits equal
//   state_o   out  [2] current state (ACTIVE=0, ISO=1, SLEEP=2, WAKE=3)
//   sleeps_o  out  [CNT_SIZE] number of SLEEP entries, wraps
module pg_ctrl #(
  parameter int PORTS_NUM   = 5,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 4,
  parameter int CNT_SIZE    = 8
) (
  input  logic                 clk,
  input  logic                 a_rst,
  input  logic [PORTS_NUM-1:0] in_w,
  input  logic                 busy,
  input  logic                 sleep_en,
  output logic                 pwr_on,
  output logic                 iso,
  output logic                 sw_rst,
  output logic [PORTS_NUM-1:0] in_r_en,
  output logic [1:0]           state_o,
  output logic [CNT_SIZE-1:0]  sleeps_o
);

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    ISO    = 2'd1,
    SLEEP  = 2'd2,
    WAKE   = 2'd3
  } state_t;

  localparam logic [CNT_SIZE-1:0] IDLE_LAST = CNT_SIZE'(IDLE_CYCLES - 1);
  localparam logic [CNT_SIZE-1:0] IDLE_MAX  = CNT_SIZE'(IDLE_CYCLES);
  localparam logic [CNT_SIZE-1:0] WAKE_LAST = CNT_SIZE'(WAKE_CYCLES - 1);
  localparam logic [CNT_SIZE-1:0] CNT_ONE   = CNT_SIZE'(1);

  state_t                state;
  state_t                next_state;
  logic [CNT_SIZE-1:0]   icnt;
  logic [CNT_SIZE-1:0]   icnt_next;
  logic [CNT_SIZE-1:0]   wcnt;
  logic [CNT_SIZE-1:0]   wcnt_next;
  logic                  sleep_inc;
  logic                  act;
  logic                  idle;

  logic                  pwr_on_next;
  logic                  iso_next;
  logic                  sw_rst_next;
  logic [PORTS_NUM-1:0]  in_r_en_next;

  assign act  = |in_w;
  assign idle = !act && !busy;

  // Next-state and counter logic. Counters default to 0 so that icnt is 0
  // outside ACTIVE (including right after an ISO abort) and wcnt is 0 on
  // every WAKE entry.
  always_comb begin
    next_state = state;
    icnt_next  = '0;
    wcnt_next  = '0;
    sleep_inc  = 1'b0;
    unique case (state)
      ACTIVE: begin
        if (sleep_en && idle) begin
          if (icnt == IDLE_LAST) begin
            next_state = ISO;
          end else begin
            icnt_next = (icnt == IDLE_MAX) ? icnt : icnt + CNT_ONE;
          end
        end
      end
      ISO: begin
        // Power is still on, so any sign of traffic cancels the gating.
        if (act || busy || !sleep_en) begin
          next_state = ACTIVE;
        end else begin
          next_state = SLEEP;
          sleep_inc  = 1'b1;
        end
      end
      SLEEP: begin
        // busy is meaningless here: the switch domain is unpowered.
        if (act || !sleep_en) begin
          next_state = WAKE;
        end
      end
      WAKE: begin
        // Settle time always runs to completion.
        if (wcnt == WAKE_LAST) begin
          next_state = ACTIVE;
        end else begin
          wcnt_next = wcnt + CNT_ONE;
        end
      end
      default: next_state = ACTIVE;
    endcase
  end

  // Output decode of the next state; registering it keeps every output a
  // clean flop that always matches the current state.
  always_comb begin
    pwr_on_next  = 1'b1;
    iso_next     = 1'b0;
    sw_rst_next  = 1'b0;
    in_r_en_next = '0;
    unique case (next_state)
      ACTIVE: in_r_en_next = {PORTS_NUM{1'b1}};
      ISO:    iso_next     = 1'b1;
      SLEEP: begin
        pwr_on_next = 1'b0;
        iso_next    = 1'b1;
        sw_rst_next = 1'b1;
      end
      WAKE: begin
        iso_next    = 1'b1;
        sw_rst_next = 1'b1;
      end
      default: in_r_en_next = {PORTS_NUM{1'b1}};
    endcase
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state    <= ACTIVE;
      icnt     <= '0;
      wcnt     <= '0;
      sleeps_o <= '0;
      pwr_on   <= 1'b1;
      iso      <= 1'b0;
      sw_rst   <= 1'b0;
      in_r_en  <= {PORTS_NUM{1'b1}};
    end else begin
      state    <= next_state;
      icnt     <= icnt_next;
      wcnt     <= wcnt_next;
      if (sleep_inc) begin
        sleeps_o <= sleeps_o + CNT_ONE;
      end
      pwr_on   <= pwr_on_next;
      iso      <= iso_next;
      sw_rst   <= sw_rst_next;
      in_r_en  <= in_r_en_next;
    end
  end

  assign state_o = state;

endmodule

// File: doc/pg_ctrl.md
# pg_ctrl

Per-node power-gating controller for the NoC router. One instance sits beside each `switch` and watches the switch's incoming write requests and its internal buffer occupancy. After a programmable run of idle cycles it isolates, resets and powers down the switch domain. On the first new write request it powers the domain back up, waits a fixed settle time and releases the upstream handshake.

## Interface
Parameters:
- `PORTS_NUM`, 5: number of switch input ports, local IP port included.
- `IDLE_CYCLES`, 16: consecutive idle cycles required before gating; must be ≥1.
- `WAKE_CYCLES`, 4: cycles from power-on to switch release; must be ≥1.
- `CNT_SIZE`, 8: width of the internal counters and `sleeps_o`. Must satisfy 2^CNT_SIZE > max(IDLE_CYCLES, WAKE_CYCLES).

Ports:
- `clk`  in  1  single clock, rising edge.
- `a_rst`  in  1  asynchronous, active-low reset.
- `in_w`  in  PORTS_NUM  upstream write requests toward the switch; a writer holds its bit until it sees `in_r`.
- `busy`  in  1  switch holds at least one buffered flit; OR of the FIFO non-empty flags.
- `sleep_en`  in  1  global gating enable.
- `pwr_on`  out  1  power-switch enable for the switch domain.
- `iso`  out  1  isolation clamp on switch outputs; 1 means clamped to 0.
- `sw_rst`  out  1  reset to the switch; 1 means held in reset.
- `in_r_en`  out  PORTS_NUM  per-port mask ANDed with the switch `in_r`; all bits equal.
- `state_o`  out  2  current state encoding.
- `sleeps_o`  out  CNT_SIZE  count of entries into SLEEP; wraps modulo 2^CNT_SIZE.

## Operation
- Definitions:
  - `act` = |in_w.
  - `idle` = !act && !busy.
- States: ACTIVE=0, ISO=1, SLEEP=2, WAKE=3.
- All outputs are registered (Moore) and decoded from the state.
- Idle counter `icnt`:
  - In ACTIVE: cleared when !idle or !sleep_en; otherwise incremented, saturating at IDLE_CYCLES.
  - In all other states: held at 0.
- Transitions:
  - ACTIVE→ISO when sleep_en && idle && icnt==IDLE_CYCLES-1, i.e. on the IDLE_CYCLES-th consecutive idle cycle.
  - ISO→ACTIVE (abort) if act || busy || !sleep_en. This takes priority because power is still on.
  - ISO→SLEEP otherwise, after exactly one cycle in ISO. `sleeps_o` increments on this transition.
  - SLEEP→WAKE when act || !sleep_en. `busy` is ignored in SLEEP because the domain is unpowered.
  - WAKE: `wcnt` loads 0 on entry and increments each cycle. WAKE→ACTIVE when wcnt==WAKE_CYCLES-1, so the block spends exactly WAKE_CYCLES cycles in WAKE.
  - WAKE is never aborted: `act` and `sleep_en` are ignored during WAKE.
- Output decode:
  - ACTIVE: pwr_on=1, iso=0, sw_rst=0, in_r_en=all 1.
  - ISO: pwr_on=1, iso=1, sw_rst=0, in_r_en=0.
  - SLEEP: pwr_on=0, iso=1, sw_rst=1, in_r_en=0.
  - WAKE: pwr_on=1, iso=1, sw_rst=1, in_r_en=0.
- No flit is lost. Upstream writers stall on `in_r`=0 and hold `in_w`, so the first request after wake is accepted in the first ACTIVE cycle.

## Timing
- Reset values: state=ACTIVE, pwr_on=1, iso=0, sw_rst=0, in_r_en=all 1, state_o=0, sleeps_o=0, icnt=0, wcnt=0. All take effect immediately on a_rst=0, independent of clk.
- Reset release: the first transition is evaluated on the first rising edge with a_rst=1.
- Gating latency: if the last non-idle cycle ends at edge t, then ISO is entered at edge t+IDLE_CYCLES and SLEEP at edge t+IDLE_CYCLES+1.
- Wake latency: if `act` is first seen in SLEEP at edge k, then WAKE starts at k, ACTIVE starts at k+WAKE_CYCLES, and in_r_en=1 from that edge.
- Simultaneous `act` and the ISO decision edge: abort wins, and the next state is ACTIVE with icnt=0.
- Reset asserted mid-WAKE or mid-SLEEP: the block jumps to ACTIVE outputs asynchronously. The switch's own reset is driven by the same a_rst.
- sleep_en=0 forces the block back to ACTIVE through WAKE if currently asleep, and blocks any new gating.
- `sleeps_o` wraps from 2^CNT_SIZE-1 to 0.

## Test plan
- Reset, then idle with sleep_en=1, IDLE_CYCLES=16 -> ISO after 16 idle cycles, SLEEP one cycle later, pwr_on=0, sleeps_o=1.
- In SLEEP, in_w[2]=1 held -> WAKE for exactly 4 cycles with pwr_on=1, iso=1, sw_rst=1, then ACTIVE with in_r_en=5'b11111 while in_w[2] is still held.
- `busy`=1 pulsed on idle cycle 15 -> icnt clears and no ISO occurs; ISO is reached 16 idle cycles after the pulse.
- in_w[0] asserted on the single ISO cycle -> back to ACTIVE, sleeps_o unchanged, pwr_on never drops.
- Asynchronous a_rst=0 pulsed mid-WAKE -> outputs go to reset values before the next edge; normal gating resumes afterwards.
- CNT_SIZE=2: four sleep/wake cycles -> sleeps_o reads 1, 2, 3, 0. Also check that sleep_en=0 in SLEEP triggers WAKE with no in_w.
